// File: rtl/sram_arbiter.sv
// Round-robin arbiter that shares one single-port SRAM between the IF and MEM ports.
// Each grant lasts LATENCY+2 cycles (grant, access, one-cycle ack); losers wait with stall_req high.
module sram_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_ack,
  input  logic                mem_req,
  input  logic                mem_we,
  input  logic [DATA_W/8-1:0] mem_sel,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic                mem_ack,
  output logic                stall_req,
  output logic                sram_ce,
  output logic                sram_we,
  output logic [DATA_W/8-1:0] sram_sel,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [DATA_W-1:0]   sram_wdata,
  input  logic [DATA_W-1:0]   sram_rdata
);

  localparam int         SEL_W    = DATA_W / 8;
  localparam logic [3:0] LAT      = 4'(LATENCY);
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_GNT_IF  = 2'd1;
  localparam logic [1:0] S_GNT_MEM = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]        r_state;
  logic [3:0]        r_cnt;
  logic              r_last_mem;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_mem_rdata;
  logic              r_if_ack;
  logic              r_mem_ack;
  logic              r_ce;
  logic              r_we;
  logic [SEL_W-1:0]  r_sel;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              w_pick_mem;

  // On a conflict the port that did not win last time gets the SRAM.
  assign w_pick_mem = mem_req & (~if_req | ~r_last_mem);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_last_mem  <= 1'b0;
      r_if_rdata  <= '0;
      r_mem_rdata <= '0;
      r_if_ack    <= 1'b0;
      r_mem_ack   <= 1'b0;
      r_ce        <= 1'b0;
      r_we        <= 1'b0;
      r_sel       <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
    end else begin
      r_if_ack  <= 1'b0;
      r_mem_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (if_req || mem_req) begin
            r_ce       <= 1'b1;
            r_cnt      <= LAT;
            r_last_mem <= w_pick_mem;
            if (w_pick_mem) begin
              r_state <= S_GNT_MEM;
              r_we    <= mem_we;
              r_sel   <= mem_sel;
              r_addr  <= mem_addr;
              r_wdata <= mem_wdata;
            end else begin
              r_state <= S_GNT_IF;
              r_we    <= 1'b0;
              r_sel   <= '1;
              r_addr  <= if_addr;
              r_wdata <= '0;
            end
          end
        end
        S_GNT_IF, S_GNT_MEM: begin
          r_cnt <= r_cnt - 4'd1;
          // Last access cycle: data is valid now, so capture it and raise ack for DONE.
          if (r_cnt == 4'd1) begin
            r_state <= S_DONE;
            r_ce    <= 1'b0;
            r_we    <= 1'b0;
            if (r_state == S_GNT_IF) begin
              r_if_ack   <= 1'b1;
              r_if_rdata <= sram_rdata;
            end else begin
              r_mem_ack <= 1'b1;
              if (!r_we) r_mem_rdata <= sram_rdata;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign if_rdata   = r_if_rdata;
  assign mem_rdata  = r_mem_rdata;
  assign if_ack     = r_if_ack;
  assign mem_ack    = r_mem_ack;
  assign sram_ce    = r_ce;
  assign sram_we    = r_we;
  assign sram_sel   = r_sel;
  assign sram_addr  = r_addr;
  assign sram_wdata = r_wdata;
  assign stall_req  = (if_req & ~r_if_ack) | (mem_req & ~r_mem_ack);

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: one instance at LATENCY=1, one at LATENCY=3 sharing stimulus.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_sel;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] sram_rdata;

  logic [31:0] if_rdata, mem_rdata, sram_addr, sram_wdata;
  logic        if_ack, mem_ack, stall_req, sram_ce, sram_we;
  logic [3:0]  sram_sel;

  logic [31:0] b_if_rdata, b_mem_rdata, b_sram_addr, b_sram_wdata;
  logic        b_if_ack, b_mem_ack, b_stall_req, b_sram_ce, b_sram_we;
  logic [3:0]  b_sram_sel;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sram_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(1)) u_lat1 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall_req(stall_req), .sram_ce(sram_ce), .sram_we(sram_we), .sram_sel(sram_sel),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  sram_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(3)) u_lat3 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(b_if_rdata), .if_ack(b_if_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(b_mem_rdata), .mem_ack(b_mem_ack),
    .stall_req(b_stall_req), .sram_ce(b_sram_ce), .sram_we(b_sram_we), .sram_sel(b_sram_sel),
    .sram_addr(b_sram_addr), .sram_wdata(b_sram_wdata), .sram_rdata(sram_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic        exp_mem;
  logic [31:0] d;
  logic [31:0] last_mem_rd;

  initial begin
    rst = 1'b0; if_req = 1'b0; if_addr = '0; mem_req = 1'b0; mem_we = 1'b0;
    mem_sel = '0; mem_addr = '0; mem_wdata = '0; sram_rdata = '0;
    last_mem_rd = '0;
    tick(); tick();
    chk("rst_if_ack", {31'd0, if_ack}, 32'd0);
    chk("rst_mem_ack", {31'd0, mem_ack}, 32'd0);
    chk("rst_ce", {31'd0, sram_ce}, 32'd0);
    chk("rst_addr", sram_addr, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_mem_rdata", mem_rdata, 32'd0);
    chk("rst_stall", {31'd0, stall_req}, 32'd0);
    rst = 1'b1;
    tick();

    // IF read, LATENCY=1
    if_req = 1'b1; if_addr = 32'h0000_0010; sram_rdata = 32'h3401_0001;
    #1;
    chk("if1_stall_req", {31'd0, stall_req}, 32'd1);
    tick();
    chk("if1_ce", {31'd0, sram_ce}, 32'd1);
    chk("if1_addr", sram_addr, 32'h0000_0010);
    chk("if1_sel", {28'd0, sram_sel}, 32'h0000_000f);
    chk("if1_we", {31'd0, sram_we}, 32'd0);
    chk("if1_ack_early", {31'd0, if_ack}, 32'd0);
    chk("if1_stall_gnt", {31'd0, stall_req}, 32'd1);
    tick();
    chk("if1_ce_off", {31'd0, sram_ce}, 32'd0);
    chk("if1_ack", {31'd0, if_ack}, 32'd1);
    chk("if1_rdata", if_rdata, 32'h3401_0001);
    chk("if1_stall_ack", {31'd0, stall_req}, 32'd0);
    if_req = 1'b0;
    tick();
    chk("if1_ack_pulse", {31'd0, if_ack}, 32'd0);
    chk("if1_rdata_hold", if_rdata, 32'h3401_0001);

    // Sustained conflict: MEM, IF, MEM, IF
    if_req = 1'b1; mem_req = 1'b1; mem_we = 1'b0; mem_sel = 4'hf; mem_addr = 32'h0000_0100;
    for (int k = 0; k < 4; k++) begin
      exp_mem = (k % 2 == 0);
      d = 32'hC0DE_0000 + 32'(k);
      sram_rdata = d;
      tick();
      chk("rr_ce", {31'd0, sram_ce}, 32'd1);
      chk("rr_addr", sram_addr, exp_mem ? 32'h0000_0100 : 32'h0000_0010);
      tick();
      chk("rr_mem_ack", {31'd0, mem_ack}, {31'd0, exp_mem});
      chk("rr_if_ack", {31'd0, if_ack}, {31'd0, ~exp_mem});
      chk("rr_rdata", exp_mem ? mem_rdata : if_rdata, d);
      if (exp_mem) last_mem_rd = d;
      tick();
      chk("rr_no_dup_grant", {31'd0, sram_ce}, 32'd0);
      if (k == 3) begin
        if_req = 1'b0;
        mem_req = 1'b0;
      end
    end

    // MEM write with partial byte enables
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h0000_0200; mem_sel = 4'b0011;
    mem_wdata = 32'hDEAD_BEEF; sram_rdata = 32'h1234_5678;
    tick();
    chk("wr_ce", {31'd0, sram_ce}, 32'd1);
    chk("wr_we", {31'd0, sram_we}, 32'd1);
    chk("wr_sel", {28'd0, sram_sel}, 32'h0000_0003);
    chk("wr_addr", sram_addr, 32'h0000_0200);
    chk("wr_wdata", sram_wdata, 32'hDEAD_BEEF);
    tick();
    chk("wr_ack", {31'd0, mem_ack}, 32'd1);
    chk("wr_we_off", {31'd0, sram_we}, 32'd0);
    chk("wr_rdata_keep", mem_rdata, last_mem_rd);
    mem_req = 1'b0; mem_we = 1'b0;
    tick();
    chk("wr_ack_pulse", {31'd0, mem_ack}, 32'd0);
    chk("wr_rdata_keep2", mem_rdata, last_mem_rd);

    // Reset in the middle of a MEM access
    mem_req = 1'b1; mem_addr = 32'h0000_0300; mem_sel = 4'hf; sram_rdata = 32'h5555_AAAA;
    tick();
    chk("rm_ce", {31'd0, sram_ce}, 32'd1);
    rst = 1'b0;
    #1;
    chk("rm_ce_clr", {31'd0, sram_ce}, 32'd0);
    chk("rm_addr_clr", sram_addr, 32'd0);
    chk("rm_sel_clr", {28'd0, sram_sel}, 32'd0);
    chk("rm_mem_rdata_clr", mem_rdata, 32'd0);
    chk("rm_if_rdata_clr", if_rdata, 32'd0);
    chk("rm_ack_clr", {31'd0, mem_ack}, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    chk("rm_no_stale_ack", {31'd0, mem_ack}, 32'd0);
    chk("rm_restart_ce", {31'd0, sram_ce}, 32'd1);
    chk("rm_restart_addr", sram_addr, 32'h0000_0300);
    tick();
    chk("rm_restart_ack", {31'd0, mem_ack}, 32'd1);
    chk("rm_restart_rdata", mem_rdata, 32'h5555_AAAA);
    mem_req = 1'b0;
    tick();

    // LATENCY=3 IF read on the second instance
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    if_req = 1'b1; if_addr = 32'h0000_0040;
    tick();
    sram_rdata = 32'h1111_1111;
    chk("l3_ce1", {31'd0, b_sram_ce}, 32'd1);
    chk("l3_addr1", b_sram_addr, 32'h0000_0040);
    tick();
    sram_rdata = 32'h2222_2222;
    chk("l3_ce2", {31'd0, b_sram_ce}, 32'd1);
    chk("l3_addr2", b_sram_addr, 32'h0000_0040);
    chk("l3_ack_early2", {31'd0, b_if_ack}, 32'd0);
    tick();
    sram_rdata = 32'h3333_3333;
    chk("l3_ce3", {31'd0, b_sram_ce}, 32'd1);
    chk("l3_addr3", b_sram_addr, 32'h0000_0040);
    chk("l3_ack_early3", {31'd0, b_if_ack}, 32'd0);
    tick();
    chk("l3_ce_off", {31'd0, b_sram_ce}, 32'd0);
    chk("l3_ack", {31'd0, b_if_ack}, 32'd1);
    chk("l3_rdata", b_if_rdata, 32'h3333_3333);
    if_req = 1'b0;
    tick();
    chk("l3_ack_pulse", {31'd0, b_if_ack}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
